// File: rtl/soc_event_queue.sv
// rtl/soc_event_queue.sv - per-source event counters, round-robin arbiter and event-ID FIFO
module soc_event_queue #(
   parameter int                         NB_SRC         = 8,
   parameter int                         EVENT_ID_WIDTH = 8,
   parameter logic [EVENT_ID_WIDTH-1:0]  ID_BASE        = '0,
   parameter int                         CNT_WIDTH      = 2,
   parameter int                         FIFO_DEPTH     = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NB_SRC-1:0]         events_i,
   output logic                      event_fifo_valid_o,
   input  logic                      event_fifo_fulln_i,
   output logic [EVENT_ID_WIDTH-1:0] event_fifo_data_o,
   output logic [NB_SRC-1:0]         overflow_o,
   input  logic [NB_SRC-1:0]         overflow_clr_i,
   output logic                      busy_o
);
   localparam int SRC_W = $clog2(NB_SRC);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
   localparam logic [PTR_W:0]       DEPTH    = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [SRC_W:0]       NB       = (SRC_W+1)'(NB_SRC);
   localparam logic [SRC_W-1:0]     LAST_SRC = SRC_W'(NB_SRC-1);

   logic [CNT_WIDTH-1:0]      cnt [NB_SRC];
   logic [EVENT_ID_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]          wr_ptr, rd_ptr;
   logic [PTR_W:0]            count;
   logic [SRC_W-1:0]          rr_ptr;
   logic [NB_SRC-1:0]         pend, grant, ovf_set;
   logic [SRC_W-1:0]          grant_idx;
   logic [SRC_W:0]            cand;
   logic                      found, grant_vld, pop, room;

   assign pop  = (count != '0) && event_fifo_fulln_i;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept a grant.
   assign room = (count != DEPTH) || pop;

   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < NB_SRC; k++) begin
         cand = {1'b0, rr_ptr} + (SRC_W+1)'(k);
         if (cand >= NB) cand = cand - NB;
         if (!found && pend[cand[SRC_W-1:0]]) begin
            found     = 1'b1;
            grant_idx = cand[SRC_W-1:0];
         end
      end
      grant_vld = found && room;
   end

   always_comb begin
      for (int i = 0; i < NB_SRC; i++) begin
         pend[i]    = (cnt[i] != '0);
         grant[i]   = grant_vld && (grant_idx == SRC_W'(i));
         ovf_set[i] = events_i[i] && !grant[i] && (cnt[i] == CNT_MAX);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < NB_SRC; i++) cnt[i] <= '0;
         for (int j = 0; j < FIFO_DEPTH; j++) mem[j] <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         rr_ptr     <= '0;
         overflow_o <= '0;
      end else begin
         for (int i = 0; i < NB_SRC; i++) begin
            if (events_i[i] && !grant[i]) begin
               if (cnt[i] != CNT_MAX) cnt[i] <= cnt[i] + 1'b1;
            end else if (!events_i[i] && grant[i]) begin
               cnt[i] <= cnt[i] - 1'b1;
            end
         end
         overflow_o <= ovf_set | (overflow_o & ~overflow_clr_i);
         if (grant_vld) begin
            mem[wr_ptr] <= ID_BASE + EVENT_ID_WIDTH'(grant_idx);
            wr_ptr      <= wr_ptr + 1'b1;
            rr_ptr      <= (grant_idx == LAST_SRC) ? '0 : grant_idx + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (grant_vld && !pop) count <= count + 1'b1;
         else if (!grant_vld && pop) count <= count - 1'b1;
      end
   end

   assign event_fifo_valid_o = (count != '0);
   assign event_fifo_data_o  = mem[rd_ptr];
   assign busy_o             = (|pend) || (count != '0);

endmodule

// File: tb/tb_soc_event_queue.sv
// tb/tb_soc_event_queue.sv - table vectors, directed corner cases and random run against a queue model
module tb_soc_event_queue;
   localparam int NB = 8;
   localparam int DEPTH = 4;
   localparam int CMAX = 3;
   localparam int BASE = 0;

   logic       clk = 1'b0;
   logic       rstn, fulln, valid, busy;
   logic [7:0] events, clr, ovf, data;

   soc_event_queue #(
      .NB_SRC(NB), .EVENT_ID_WIDTH(8), .ID_BASE(8'(BASE)), .CNT_WIDTH(2), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk_i(clk), .rst_ni(rstn), .events_i(events),
      .event_fifo_valid_o(valid), .event_fifo_fulln_i(fulln), .event_fifo_data_o(data),
      .overflow_o(ovf), .overflow_clr_i(clr), .busy_o(busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   int         mcnt [NB];
   bit [NB-1:0] movf;
   int         mq [$];
   int         mp;

   typedef struct {
      logic [7:0] ev; logic fn; logic [7:0] cl; logic rn;
      logic v; logic dchk; logic [7:0] d; logic [7:0] o; logic b;
   } vec_t;
   vec_t tbl [$];

   function automatic void add(logic [7:0] ev, logic fn, logic [7:0] cl, logic rn,
                               logic v, logic dchk, logic [7:0] d, logic [7:0] o, logic b);
      vec_t r;
      r.ev = ev; r.fn = fn; r.cl = cl; r.rn = rn;
      r.v = v; r.dchk = dchk; r.d = d; r.o = o; r.b = b;
      tbl.push_back(r);
   endfunction

   // Spec-level model: integer counters, a queue for the FIFO, first pending source from the pointer.
   function automatic void model_step(logic [7:0] ev, logic fn, logic [7:0] cl, logic rn);
      int g;
      int c;
      bit popped;
      if (!rn) begin
         foreach (mcnt[i]) mcnt[i] = 0;
         movf = '0;
         mq.delete();
         mp = 0;
         return;
      end
      g = -1;
      popped = (mq.size() > 0) && fn;
      if (mq.size() < DEPTH || popped)
         for (int k = 0; k < NB; k++)
            if (g < 0 && mcnt[(mp + k) % NB] > 0) g = (mp + k) % NB;
      if (popped) void'(mq.pop_front());
      if (g >= 0) begin
         mq.push_back((BASE + g) % 256);
         mp = (g + 1) % NB;
      end
      for (int i = 0; i < NB; i++) begin
         c = mcnt[i] + (ev[i] ? 1 : 0) - ((g == i) ? 1 : 0);
         if (c > CMAX) begin
            c = CMAX;
            movf[i] = 1'b1;
         end else if (cl[i]) begin
            movf[i] = 1'b0;
         end
         mcnt[i] = c;
      end
   endfunction

   function automatic bit m_busy();
      bit b = (mq.size() != 0);
      foreach (mcnt[i]) if (mcnt[i] != 0) b = 1'b1;
      return b;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cycle(input logic [7:0] ev, input logic fn, input logic [7:0] cl, input logic rn);
      events = ev; fulln = fn; clr = cl; rstn = rn;
      @(posedge clk);
      model_step(ev, fn, cl, rn);
      @(negedge clk);
      chk("model_valid", 32'(valid), 32'(mq.size() != 0));
      if (mq.size() != 0) chk("model_data", 32'(data), 32'(mq[0]));
      chk("model_ovf", 32'(ovf), 32'(movf));
      chk("model_busy", 32'(busy), 32'(m_busy()));
   endtask

   task automatic apply_rows(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         cycle(tbl[i].ev, tbl[i].fn, tbl[i].cl, tbl[i].rn);
         chk($sformatf("row%0d_valid", i), 32'(valid), 32'(tbl[i].v));
         chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].b));
         chk($sformatf("row%0d_ovf", i), 32'(ovf), 32'(tbl[i].o));
         if (tbl[i].dchk) chk($sformatf("row%0d_data", i), 32'(data), 32'(tbl[i].d));
      end
   endtask

   initial begin
      int t5, n3;
      events = '0; fulln = 1'b1; clr = '0; rstn = 1'b0;

      // rows 0..4: reset then a single event on source 2
      add(8'h00, 1, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0);
      add(8'h04, 1, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1);
      add(8'h00, 1, 8'h00, 1, 1, 1, 8'h02, 8'h00, 1);
      add(8'h00, 1, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0);
      add(8'h00, 1, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0);
      // rows 5..15: all sources at once, IDs in order on consecutive cycles
      add(8'h00, 1, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0);
      add(8'hFF, 1, 8'h00, 1, 0, 0, 8'h00, 8'h00, 1);
      for (int k = 0; k < NB; k++) add(8'h00, 1, 8'h00, 1, 1, 1, 8'(BASE + k), 8'h00, 1);
      add(8'h00, 1, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0);

      apply_rows(0, 4);
      apply_rows(5, tbl.size() - 1);

      // backpressure: sources 0..5 at once, FIFO holds 0..3
      cycle(8'h00, 0, 8'h00, 0);
      cycle(8'h3F, 0, 8'h00, 1);
      for (int k = 0; k < 6; k++) cycle(8'h00, 0, 8'h00, 1);
      chk("bp_valid", 32'(valid), 1);
      chk("bp_head", 32'(data), 32'(BASE));
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("bp_order%0d", k), 32'(data), 32'(BASE + k));
         cycle(8'h00, 1, 8'h00, 1);
      end
      chk("bp_drained", 32'(valid), 0);
      chk("bp_no_ovf", 32'(ovf), 0);

      // saturation on source 3 behind a full FIFO
      cycle(8'h00, 0, 8'h00, 0);
      cycle(8'h17, 0, 8'h00, 1);
      for (int k = 0; k < 4; k++) cycle(8'h00, 0, 8'h00, 1);
      for (int k = 0; k < 3; k++) cycle(8'h08, 0, 8'h00, 1);
      chk("sat_no_ovf_at_max", 32'(ovf[3]), 0);
      cycle(8'h08, 0, 8'h00, 1);
      chk("sat_ovf_set", 32'(ovf[3]), 1);
      cycle(8'h08, 0, 8'h08, 1);
      chk("sat_set_beats_clr", 32'(ovf[3]), 1);
      cycle(8'h00, 0, 8'h08, 1);
      chk("sat_clr", 32'(ovf[3]), 0);
      n3 = 0;
      for (int k = 0; k < 12; k++) begin
         if (valid && data == 8'(BASE + 3)) n3++;
         cycle(8'h00, 1, 8'h00, 1);
      end
      chk("sat_id3_count", 32'(n3), 3);
      chk("sat_drained", 32'(busy), 0);

      // fairness: source 0 every cycle, source 5 once
      cycle(8'h00, 1, 8'h00, 0);
      t5 = -1;
      for (int t = 0; t < 20; t++) begin
         cycle(8'h01 | ((t == 3) ? 8'h20 : 8'h00), 1, 8'h00, 1);
         if (t5 < 0 && valid && data == 8'(BASE + 5)) t5 = t;
      end
      chk("fair_id5_seen", 32'(t5 >= 0), 1);
      chk("fair_latency", 32'(t5 >= 0 && t5 - 3 <= NB), 1);

      // reset mid-stream with full FIFO, pending counters and an overflow flag
      cycle(8'h00, 0, 8'h00, 0);
      cycle(8'h0F, 0, 8'h00, 1);
      for (int k = 0; k < 4; k++) cycle(8'h00, 0, 8'h00, 1);
      for (int k = 0; k < 4; k++) cycle(8'h40, 0, 8'h00, 1);
      cycle(8'h30, 0, 8'h00, 1);
      chk("mid_ovf_before", 32'(ovf[6]), 1);
      cycle(8'hFF, 0, 8'h00, 0);
      chk("mid_valid", 32'(valid), 0);
      chk("mid_busy", 32'(busy), 0);
      chk("mid_ovf", 32'(ovf), 0);
      apply_rows(1, 4);

      // randomized traffic with occasional resets
      cycle(8'h00, 1, 8'h00, 0);
      for (int k = 0; k < 1500; k++)
         cycle(8'($urandom & $urandom), $urandom_range(0, 3) != 0,
               ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00,
               $urandom_range(0, 299) != 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
